stream_take_sum: RTL and testbench

Downstream consumer for `tests_repeat_int` and other stream producers. On a start handshake it latches a count `k` and accepts exactly `k` elements from an `intN` stream. It accumulates their sum and presents the result as a simple value under a valid/ready handshake. This closes a repeat→take→reduce chain and gives benches a single scalar to check instead of a sampled stream.

---
 rtl/stream_take_sum_pkg.sv | 11 +
 rtl/stream_take_sum_add.sv | 26 ++
 rtl/stream_take_sum.sv | 107 ++++++++++
 tb/tb_stream_take_sum.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_take_sum_pkg.sv
// Shared definitions for stream_take_sum: the controller state encoding.
package stream_take_sum_pkg;

    // IDLE waits for a start, TAKE consumes k stream elements, DONE offers the sum.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stream_take_sum_add.sv
// take_sum_add: N-bit accumulator adder.
// Default build wraps mod 2^N; with STREAM_TAKE_SUM_SATURATE_EN defined the
// add clamps at 2^N-1. A clamped sum stays clamped because max + x >= max.
module take_sum_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

`ifdef STREAM_TAKE_SUM_SATURATE_EN
    // Saturating add: any carry out of the top bit pins the result at all-ones.
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] z);
        logic [N:0] t;
        t = {1'b0, x} + {1'b0, z};
        return t[N] ? {N{1'b1}} : t[N-1:0];
    endfunction

    assign y = sat_add(a, b);
`else
    // Plain modular add; the carry out is intentionally dropped.
    assign y = a + b;
`endif

endmodule

// File: rtl/stream_take_sum.sv
// stream_take_sum: latch a count k on a start handshake, accept exactly k
// elements from the input stream, and present their sum under valid/ready.
// Optional feature macro: STREAM_TAKE_SUM_SATURATE_EN (saturating add,
// implemented in take_sum_add). Sequencing is the same in both builds.
module stream_take_sum
    import stream_take_sum_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] dCount,
    input  logic [N-1:0]  sIn,
    input  logic          sIn_valid,
    output logic          sIn_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  dOut
);

    state_e        state_q, state_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  add_y;

    take_sum_add #(.N(N)) u_add (
        .a (sum_q),
        .b (sIn),
        .y (add_y)
    );

    // Readies depend on state alone so no input can reach them combinationally.
    assign in_ready  = (state_q == ST_IDLE);
    assign sIn_ready = (state_q == ST_TAKE);
    assign out_valid = out_valid_q;
    assign dOut      = dout_q;

    // Next-state and datapath updates; everything holds unless a handshake fires.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d = dCount;
                    sum_d = '0;
                    if (dCount == '0) begin
                        // Empty take: the result is the zero sum, offered next cycle.
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        dout_d      = '0;
                    end else begin
                        state_d = ST_TAKE;
                    end
                end
            end
            ST_TAKE: begin
                if (sIn_valid) begin
                    sum_d = add_y;
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        // Last element: publish the sum including this element.
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        dout_d      = add_y;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and data registers; a low nrst aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            rem_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_stream_take_sum.sv
// Bench for stream_take_sum: directed scenarios, a transaction-level
// reference model checked every cycle, plus literal expected sums.
module tb_stream_take_sum;

    localparam int N  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] dCount = '0;
    logic [N-1:0]  sIn = '0;
    logic          sIn_valid = 1'b0;
    logic          sIn_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  dOut;

    int total = 0;
    int bad   = 0;
    int hs    = 0;

    stream_take_sum #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dCount    (dCount),
        .sIn       (sIn),
        .sIn_valid (sIn_valid),
        .sIn_ready (sIn_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dOut      (dOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a job is "busy taking" with some elements left, or a
    // result is pending; the sum is kept as an unbounded integer and folded
    // into N bits only when the result is published.
    bit m_live = 0;
    bit m_job  = 0;
    bit m_res  = 0;
    int m_left = 0;
    int m_acc  = 0;
    int m_result = 0;

    function automatic int fold(input int acc);
`ifdef STREAM_TAKE_SUM_SATURATE_EN
        return (acc > 255) ? 255 : acc;
`else
        return acc % 256;
`endif
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            m_live = 1; m_job = 0; m_res = 0; m_left = 0; m_acc = 0;
        end else if (m_res) begin
            if (out_ready) m_res = 0;
        end else if (m_job) begin
            if (sIn_valid) begin
                m_acc  = m_acc + int'(sIn);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_job = 0; m_res = 1; m_result = fold(m_acc);
                end
            end
        end else if (in_valid) begin
            m_acc = 0;
            if (dCount == 0) begin
                m_res = 1; m_result = 0;
            end else begin
                m_job = 1; m_left = int'(dCount);
            end
        end
    end

    // Count actual stream handshakes as seen at the clock edge.
    always @(posedge clk) begin
        if (nrst && sIn_valid && sIn_ready) hs++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", in_ready, (!m_job && !m_res));
            chk("sIn_ready", sIn_ready, m_job);
            chk("out_valid", out_valid, m_res);
            if (m_res) chk("dOut_model", dOut, m_result);
        end
    end

    task automatic start(input int k);
        in_valid = 1'b1; dCount = CW'(k);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int v);
        sIn_valid = 1'b1; sIn = N'(v);
        @(posedge clk); #1;
        sIn_valid = 1'b0;
    endtask

    task automatic feed_gap(input int v);
        feed(v);
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input string name, input int exp);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk(name, dOut, exp);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sIn_ready", sIn_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dOut", dOut, 0);
        @(posedge clk); #1;

        // 42 x 3, out_ready high, extra stream data offered afterwards
        hs = 0;
        out_ready = 1'b1;
        start(3);
        feed(42); feed(42); feed(42);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        chk("sum_42x3", dOut, 126);
        sIn_valid = 1'b1; sIn = 8'd42;
        repeat (3) @(posedge clk);
        #1 sIn_valid = 1'b0; out_ready = 1'b0;
        chk("handshakes_3", hs, 3);

        // 100 x 3: wrap or saturate
        start(3);
        feed(100); feed(100); feed(100);
`ifdef STREAM_TAKE_SUM_SATURATE_EN
        wait_out("sum_100x3", 255);
`else
        wait_out("sum_100x3", 44);
`endif
        release_out();

        // k = 0: result next cycle, never ready for the stream
        hs = 0;
        sIn_valid = 1'b1; sIn = 8'd9;
        start(0);
        @(negedge clk);
        chk("k0_out_valid", out_valid, 1);
        chk("k0_dOut", dOut, 0);
        release_out();
        sIn_valid = 1'b0;
        chk("k0_handshakes", hs, 0);

        // 1,2,3,4 with gaps; hold result 5 cycles under backpressure
        start(4);
        feed_gap(1); feed_gap(2); feed_gap(3); feed(4);
        wait_out("sum_1234", 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_dOut", dOut, 10);
            chk("hold_valid", out_valid, 1);
        end
        release_out();
        @(negedge clk);
        chk("after_rel_in_ready", in_ready, 1);
        chk("after_rel_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Abort mid-transaction, then a fresh run
        start(4);
        feed(7); feed(8);
        nrst = 1'b0; sIn_valid = 1'b1; sIn = 8'd50;
        @(posedge clk); #1;
        nrst = 1'b1; sIn_valid = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        start(2);
        feed(5); feed(6);
        wait_out("sum_after_abort", 11);
        release_out();

        // in_valid held through TAKE and DONE: no restart until IDLE
        in_valid = 1'b1; dCount = 8'd2;
        @(posedge clk); #1;
        dCount = 8'd7;
        feed(3); feed(4);
        dCount = 8'd1;
        wait_out("sum_hold_start", 7);
        @(negedge clk);
        @(negedge clk);
        chk("hold_start_dOut", dOut, 7);
        release_out();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("relatch_sIn_ready", sIn_ready, 1);
        feed(9);
        wait_out("sum_relatch", 9);
        release_out();

        // Maximum count: 255 elements of 2
        start(255);
        for (int i = 0; i < 255; i++) feed(2);
`ifdef STREAM_TAKE_SUM_SATURATE_EN
        wait_out("sum_max_count", 255);
`else
        wait_out("sum_max_count", 254);
`endif
        release_out();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
